// File: rtl/ospfb_phasecomp_reader.sv
// ospfb_phasecomp_reader: drains ping-pong sample banks A/B alternately onto an AXI-stream,
// rotating the read start by DEC_FAC per frame when OSPFB_PHASECOMP_ROT_EN is defined.
`default_nettype none

module ospfb_phasecomp_reader #(
    parameter int FFT_LEN = 64,
    parameter int DEC_FAC = 48,
    parameter int WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 bank_full,
    output logic [1:0]                 bank_release,
    output logic                       rd_en,
    output logic                       rd_bank,
    output logic [$clog2(FFT_LEN)-1:0] rd_addr,
    input  logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [31:0]                frame_cnt
);

    localparam int AW = $clog2(FFT_LEN);
    localparam int EW = WIDTH + 2;
    localparam logic [AW-1:0] LAST_K = AW'(FFT_LEN - 1);

    if (DEC_FAC <= 0 || DEC_FAC >= FFT_LEN) begin : g_bad_dec_fac
        $error("DEC_FAC must satisfy 0 < DEC_FAC < FFT_LEN");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN_A = 2'd1,
        DRAIN_B = 2'd2
    } state_t;

    state_t          state;
    logic            exp_bank;
    logic [AW-1:0]   offset;
    logic [AW-1:0]   k;
    logic            rd_last;
    logic            pend, pend_last, pend_bank;
    logic [EW-1:0]   skid0, skid1;
    logic [1:0]      skid_cnt;
    logic            out_bank;

    logic            pop, take, issue, go_read, can_issue, nxt_bank, last_rd;
    logic [2:0]      occupancy;
    logic [EW-1:0]   incoming, out_cur, out_n, skid0_n, skid1_n;
    logic            ov_n;
    logic [1:0]      skid_cnt_n;

    assign pop      = m_axis_tvalid && m_axis_tready;
    assign take     = !m_axis_tvalid || m_axis_tready;
    assign incoming = {pend_bank, pend_last, rd_data};
    assign out_cur  = {out_bank, m_axis_tlast, m_axis_tdata};
    assign nxt_bank = ~exp_bank;
    assign last_rd  = (k == LAST_K);

    // Output register plus two skid slots hold three words; counting the two reads
    // still in the RAM pipe guarantees every issued read has a slot to land in.
    assign occupancy = {2'b00, m_axis_tvalid} + {1'b0, skid_cnt} + {2'b00, pend} + {2'b00, rd_en};
    assign can_issue = occupancy <= (3'd2 + {2'b00, pop});
    assign go_read   = (state != IDLE) || bank_full[exp_bank];
    assign issue     = go_read && can_issue;

    assign bank_release = {pop && m_axis_tlast && out_bank, pop && m_axis_tlast && !out_bank};

    always_comb begin
        skid0_n    = skid0;
        skid1_n    = skid1;
        skid_cnt_n = skid_cnt;
        out_n      = out_cur;
        ov_n       = m_axis_tvalid;
        if (take) begin
            if (skid_cnt != 2'd0) begin
                out_n      = skid0;
                ov_n       = 1'b1;
                skid0_n    = skid1;
                skid_cnt_n = skid_cnt - 2'd1;
            end else if (pend) begin
                out_n = incoming;
                ov_n  = 1'b1;
            end else begin
                ov_n = 1'b0;
            end
        end
        if (pend && !(take && skid_cnt == 2'd0)) begin
            if (skid_cnt_n == 2'd0) begin
                skid0_n = incoming;
            end else begin
                skid1_n = incoming;
            end
            skid_cnt_n = skid_cnt_n + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            exp_bank      <= 1'b0;
            offset        <= '0;
            k             <= '0;
            rd_en         <= 1'b0;
            rd_bank       <= 1'b0;
            rd_addr       <= '0;
            rd_last       <= 1'b0;
            pend          <= 1'b0;
            pend_last     <= 1'b0;
            pend_bank     <= 1'b0;
            skid0         <= '0;
            skid1         <= '0;
            skid_cnt      <= 2'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            out_bank      <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            pend          <= rd_en;
            pend_last     <= rd_last;
            pend_bank     <= rd_bank;
            skid0         <= skid0_n;
            skid1         <= skid1_n;
            skid_cnt      <= skid_cnt_n;
            m_axis_tvalid <= ov_n;
            {out_bank, m_axis_tlast, m_axis_tdata} <= out_n;
            if (pop && m_axis_tlast) begin
                frame_cnt <= frame_cnt + 32'd1;
            end
            if (issue) begin
                rd_en   <= 1'b1;
                rd_bank <= exp_bank;
                rd_addr <= k + offset;
                rd_last <= last_rd;
                if (last_rd) begin
                    // Frame fully read: hop straight to the other bank if it is already waiting.
                    k        <= '0;
                    exp_bank <= nxt_bank;
`ifdef OSPFB_PHASECOMP_ROT_EN
                    offset   <= offset + AW'(DEC_FAC);
`else
                    offset   <= '0;
`endif
                    if (bank_full[nxt_bank]) begin
                        state <= nxt_bank ? DRAIN_B : DRAIN_A;
                    end else begin
                        state <= IDLE;
                    end
                end else begin
                    k     <= k + AW'(1);
                    state <= exp_bank ? DRAIN_B : DRAIN_A;
                end
            end else begin
                rd_en <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ospfb_phasecomp_reader.sv
// tb_ospfb_phasecomp_reader: scoreboard bench; bank RAM holds {bank tag, address} per word.
`default_nettype none

module tb_ospfb_phasecomp_reader;

    localparam int FFT_LEN = 64;
    localparam int DEC_FAC = 48;
    localparam int WIDTH   = 16;
    localparam int AW      = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        bank_full;
    logic [1:0]        bank_release;
    logic              rd_en, rd_bank;
    logic [AW-1:0]     rd_addr;
    logic [WIDTH-1:0]  rd_data = '0;
    logic [WIDTH-1:0]  tdata;
    logic              tvalid, tlast;
    logic              tready = 1'b0;
    logic [31:0]       frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [WIDTH+2:0] exp_q[$];
    logic [WIDTH+2:0] obs_q[$];
    int               obs_cyc[$];
    int               cyc = 0;
    int               stab_viol = 0;
    int               rel_seen[2] = '{0, 0};
    int               fill_tgt[2] = '{0, 0};
    logic             hold_v = 1'b0;
    logic [WIDTH:0]   hold_val = '0;

    assign bank_full[0] = fill_tgt[0] > rel_seen[0];
    assign bank_full[1] = fill_tgt[1] > rel_seen[1];

    ospfb_phasecomp_reader #(.FFT_LEN(FFT_LEN), .DEC_FAC(DEC_FAC), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .bank_full(bank_full), .bank_release(bank_release),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= (rd_bank ? 16'h0100 : 16'h0000) | 16'(rd_addr);
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (tvalid && tready) begin
                obs_q.push_back({bank_release, tlast, tdata});
                obs_cyc.push_back(cyc);
            end
            if (hold_v && (!tvalid || {tlast, tdata} !== hold_val)) stab_viol <= stab_viol + 1;
            hold_v   <= tvalid && !tready;
            hold_val <= {tlast, tdata};
            if (bank_release[0]) rel_seen[0] <= rel_seen[0] + 1;
            if (bank_release[1]) rel_seen[1] <= rel_seen[1] + 1;
        end else begin
            hold_v <= 1'b0;
        end
    end

    function automatic int off_of(input int f);
`ifdef OSPFB_PHASECOMP_ROT_EN
        return (f * DEC_FAC) % FFT_LEN;
`else
        return 0;
`endif
    endfunction

    task automatic push_frame(input bit bank, input int off, input int nbeats);
        logic [WIDTH+2:0] e;
        for (int i = 0; i < nbeats; i++) begin
            e[WIDTH-1:0] = (bank ? 16'h0100 : 16'h0000) | 16'((i + off) % FFT_LEN);
            e[WIDTH]     = (i == FFT_LEN - 1);
            e[WIDTH+2:WIDTH+1] = (i == FFT_LEN - 1) ? (bank ? 2'b10 : 2'b01) : 2'b00;
            exp_q.push_back(e);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n  = 1'b0;
        tready = 1'b0;
        fill_tgt[0] = rel_seen[0];
        fill_tgt[1] = rel_seen[1];
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        rst_n = 1'b1;
    endtask

    task automatic collect(input int n, input int budget, input bit rnd, output bit to);
        int c;
        c  = 0;
        to = 1'b0;
        while (obs_q.size() < n) begin
            @(posedge clk); #1;
            if (rnd) tready = 1'($urandom_range(0, 1));
            c++;
            if (c > budget) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({tvalid, tlast, tdata} !== '0) begin
            errors++; $display("FAIL reset_axis got %h want 0", {tvalid, tlast, tdata});
        end
        checks++;
        if ({rd_en, rd_bank, rd_addr} !== '0) begin
            errors++; $display("FAIL reset_rd got %h want 0", {rd_en, rd_bank, rd_addr});
        end
        checks++;
        if (bank_release !== 2'b00) begin
            errors++; $display("FAIL reset_release got %b want 00", bank_release);
        end
        checks++;
        if (frame_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt);
        end
        reset_dut();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (tvalid !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_idle got tvalid=%b rd_en=%b want 0", tvalid, rd_en);
        end
    endtask

    task automatic test_rotation(input bit rnd);
        bit to;
        int n, s0;
        logic [WIDTH+2:0] g, e;
        reset_dut();
        s0 = stab_viol;
        fill_tgt[0] = rel_seen[0] + 3;
        fill_tgt[1] = rel_seen[1] + 2;
        tready = 1'b1;
        for (int f = 0; f < 5; f++) push_frame(f[0], off_of(f), FFT_LEN);
        n = exp_q.size();
        collect(n, rnd ? 4000 : 1000, rnd, to);
        tready = 1'b1;
        checks++;
        if (to) begin
            errors++; $display("FAIL stream_timeout got %0d beats want %0d", obs_q.size(), n);
        end
        if (!rnd && obs_cyc.size() >= n) begin
            checks++;
            if (obs_cyc[n-1] - obs_cyc[0] != n - 1) begin
                errors++; $display("FAIL no_gaps got span %0d want %0d", obs_cyc[n-1] - obs_cyc[0], n - 1);
            end
        end
        for (int i = 0; i < n && obs_q.size() > 0; i++) begin
            g = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL beat%0d rnd=%0d got %h want %h", i, rnd, g, e);
            end
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0 || tvalid !== 1'b0) begin
            errors++; $display("FAIL extra_beats got %0d want 0", obs_q.size());
        end
        checks++;
        if (frame_cnt !== 32'd5) begin
            errors++; $display("FAIL frame_cnt got %0d want 5", frame_cnt);
        end
        checks++;
        if (stab_viol != s0) begin
            errors++; $display("FAIL hold_stable got %0d violations want 0", stab_viol - s0);
        end
        obs_cyc.delete();
    endtask

    task automatic test_wrong_bank();
        bit to, bad;
        logic [WIDTH+2:0] g, e;
        reset_dut();
        tready = 1'b1;
        fill_tgt[1] = rel_seen[1] + 1;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (tvalid || rd_en) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++; $display("FAIL b_only_idle got activity=%b want 0", bad);
        end
        fill_tgt[0] = rel_seen[0] + 1;
        push_frame(1'b0, off_of(0), FFT_LEN);
        push_frame(1'b1, off_of(1), FFT_LEN);
        collect(2 * FFT_LEN, 1000, 1'b0, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL a_start_timeout got %0d beats want %0d", obs_q.size(), 2 * FFT_LEN);
        end
        for (int i = 0; i < 2 * FFT_LEN && obs_q.size() > 0; i++) begin
            g = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL ab_beat%0d got %h want %h", i, g, e);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (frame_cnt !== 32'd2) begin
            errors++; $display("FAIL ab_frame_cnt got %0d want 2", frame_cnt);
        end
        obs_cyc.delete();
    endtask

    task automatic test_reset_midframe();
        bit to;
        int r0, r1, n;
        logic [WIDTH+2:0] g, e;
        reset_dut();
        tready = 1'b1;
        fill_tgt[0] = rel_seen[0] + 2;
        fill_tgt[1] = rel_seen[1] + 1;
        push_frame(1'b0, off_of(0), FFT_LEN);
        push_frame(1'b1, off_of(1), 20);
        n = exp_q.size();
        collect(n, 1000, 1'b0, to);
        rst_n = 1'b0;
        r0 = rel_seen[0];
        r1 = rel_seen[1];
        #1;
        checks++;
        if (tvalid !== 1'b0 || bank_release !== 2'b00) begin
            errors++; $display("FAIL mid_reset got tvalid=%b rel=%b want 0", tvalid, bank_release);
        end
        checks++;
        if (to) begin
            errors++; $display("FAIL mid_timeout got %0d beats want %0d", obs_q.size(), n);
        end
        for (int i = 0; i < n && obs_q.size() > 0; i++) begin
            g = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL mid_beat%0d got %h want %h", i, g, e);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rel_seen[1] != r1 || rel_seen[0] != r0 || frame_cnt !== 32'd0) begin
            errors++; $display("FAIL mid_no_release got relB=%0d cnt=%0d want relB=%0d cnt=0", rel_seen[1], frame_cnt, r1);
        end
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        fill_tgt[1] = rel_seen[1];
        rst_n = 1'b1;
        push_frame(1'b0, 0, FFT_LEN);
        collect(FFT_LEN, 1000, 1'b0, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL restart_timeout got %0d beats want %0d", obs_q.size(), FFT_LEN);
        end
        for (int i = 0; i < FFT_LEN && obs_q.size() > 0; i++) begin
            g = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++; $display("FAIL restart_beat%0d got %h want %h", i, g, e);
            end
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (frame_cnt !== 32'd1) begin
            errors++; $display("FAIL restart_frame_cnt got %0d want 1", frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rotation(1'b0);
        test_rotation(1'b1);
        test_wrong_bank();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
